// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter/rotator: one bit position per clock, with a start/busy/done handshake.
// Reports the last bit shifted out (cout), a registered zero flag, and an illegal-op flag.
module seq_shift_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sout,
    output logic             cout,
    output logic             zero,
    output logic             err
);

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_LSL  = 3'b001;
    localparam logic [2:0] OP_LSR  = 3'b010;
    localparam logic [2:0] OP_ASR  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [2:0]       op_r;
    logic [AMT_W-1:0] cnt;
    logic [WIDTH:0]   nxt;
    logic             illegal;
    logic             no_steps;

    // One 1-bit step; the MSB of the result is the bit leaving the register.
    function automatic logic [WIDTH:0] step(input logic [2:0] o, input logic [WIDTH-1:0] w);
        logic [WIDTH:0] r;
        case (o)
            OP_LSL:  r = {w[WIDTH-1], w[WIDTH-2:0], 1'b0};
            OP_LSR:  r = {w[0], 1'b0, w[WIDTH-1:1]};
            OP_ASR:  r = {w[0], w[WIDTH-1], w[WIDTH-1:1]};
            OP_ROR:  r = {w[0], w[0], w[WIDTH-1:1]};
            OP_ROL:  r = {w[WIDTH-1], w[WIDTH-2:0], w[WIDTH-1]};
            default: r = {1'b0, w};
        endcase
        return r;
    endfunction

    always_comb begin
        nxt      = step(op_r, sout);
        illegal  = (op[2:1] == 2'b11);
        no_steps = illegal || (op == OP_PASS) || (amt == '0);
    end

    // sout doubles as the working register, so intermediate values are visible while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            op_r  <= OP_PASS;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sout  <= '0;
            cout  <= 1'b0;
            zero  <= 1'b1;
            err   <= 1'b0;
        end else if (start && (state == IDLE || state == DONE)) begin
            op_r <= op;
            cnt  <= amt;
            sout <= in;
            zero <= (in == '0);
            cout <= 1'b0;
            err  <= illegal;
            if (no_steps) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end else begin
                state <= SHIFT;
                busy  <= 1'b1;
                done  <= 1'b0;
            end
        end else begin
            case (state)
                SHIFT: begin
                    sout <= nxt[WIDTH-1:0];
                    zero <= (nxt[WIDTH-1:0] == '0);
                    cout <= nxt[WIDTH];
                    cnt  <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed self-checking bench for seq_shift_unit (WIDTH=16, AMT_W=5).
module tb_seq_shift_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] din;
    logic [2:0]  opc;
    logic [4:0]  amt;
    logic        busy, done, cout, zero, err;
    logic [15:0] sout;

    int tests = 0;
    int fails = 0;

    seq_shift_unit #(.WIDTH(16), .AMT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .in(din), .op(opc), .amt(amt),
        .busy(busy), .done(done), .sout(sout), .cout(cout), .zero(zero), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // busy and done must never be high together
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            tests++;
            assert ((busy & done) === 1'b0) else begin
                fails++;
                $error("FAIL busy_done_overlap: observed busy=%b done=%b expected not both", busy, done);
            end
        end
    end

    // Drive a request for one edge, then scramble inputs to prove they were captured.
    task automatic start_op(input logic [15:0] i, input logic [2:0] o, input logic [4:0] a);
        @(negedge clk);
        din = i; opc = o; amt = a; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; din = 16'h5A5A; opc = 3'b001; amt = 5'd7;
    endtask

    task automatic wait_done(output int lat, output bit saw_busy);
        lat = 0;
        saw_busy = 1'b0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) saw_busy = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic res_chk(input string tag, input int lat, input int exp_lat,
                           input logic [15:0] es, input logic ec, input logic ez, input logic ee);
        chk({tag, "_lat"},  32'(lat), 32'(exp_lat));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_sout"}, 32'(sout), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_zero"}, 32'(zero), 32'(ez));
        chk({tag, "_err"},  32'(err),  32'(ee));
    endtask

    initial begin
        int lat;
        bit sb;
        bit saw_done;
        reset = 1'b1; start = 1'b0; din = '0; opc = '0; amt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sout", 32'(sout), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_err",  32'(err),  32'd0);
        @(negedge clk); reset = 1'b0;

        // Basic shifts
        start_op(16'hB00D, 3'b001, 5'd4); wait_done(lat, sb);
        res_chk("lsl4", lat, 4, 16'h00D0, 1'b1, 1'b0, 1'b0);
        start_op(16'hB00D, 3'b010, 5'd1); wait_done(lat, sb);
        res_chk("lsr1", lat, 1, 16'h5806, 1'b1, 1'b0, 1'b0);
        start_op(16'hB00D, 3'b011, 5'd3); wait_done(lat, sb);
        res_chk("asr3", lat, 3, 16'hF601, 1'b1, 1'b0, 1'b0);

        // Rotates
        start_op(16'h8001, 3'b100, 5'd1); wait_done(lat, sb);
        res_chk("ror1", lat, 1, 16'hC000, 1'b1, 1'b0, 1'b0);
        start_op(16'h8001, 3'b101, 5'd16); wait_done(lat, sb);
        res_chk("rol16", lat, 16, 16'h8001, 1'b1, 1'b0, 1'b0);

        // Zero amount, pass, illegal: done next cycle, busy never rises
        start_op(16'h1234, 3'b001, 5'd0); wait_done(lat, sb);
        res_chk("amt0", lat, 0, 16'h1234, 1'b0, 1'b0, 1'b0);
        chk("amt0_nobusy", 32'(sb), 32'd0);
        start_op(16'hABCD, 3'b000, 5'd9); wait_done(lat, sb);
        res_chk("pass", lat, 0, 16'hABCD, 1'b0, 1'b0, 1'b0);
        chk("pass_nobusy", 32'(sb), 32'd0);
        start_op(16'h0F0F, 3'b111, 5'd3); wait_done(lat, sb);
        res_chk("ill", lat, 0, 16'h0F0F, 1'b0, 1'b0, 1'b1);
        chk("ill_nobusy", 32'(sb), 32'd0);
        @(posedge clk); #1;
        chk("ill_err_held", 32'(err), 32'd1);
        chk("ill_sout_held", 32'(sout), 32'h0F0F);
        chk("ill_done_pulse", 32'(done), 32'd0);

        // Large amounts and flags
        start_op(16'h8000, 3'b011, 5'd20); wait_done(lat, sb);
        res_chk("asr20", lat, 20, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        start_op(16'h8000, 3'b010, 5'd16); wait_done(lat, sb);
        res_chk("lsr16", lat, 16, 16'h0000, 1'b1, 1'b1, 1'b0);
        start_op(16'h0000, 3'b000, 5'd0); wait_done(lat, sb);
        res_chk("pass0", lat, 0, 16'h0000, 1'b0, 1'b1, 1'b0);

        // start pulsed during SHIFT is ignored
        start_op(16'hB00D, 3'b001, 5'd4);
        @(negedge clk); start = 1'b1; din = 16'h0000; opc = 3'b000; amt = 5'd0;
        @(posedge clk); #1; start = 1'b0;
        chk("ign_busy", 32'(busy), 32'd1);
        wait_done(lat, sb);
        res_chk("ign", lat + 1, 4, 16'h00D0, 1'b1, 1'b0, 1'b0);

        // Back-to-back accept from DONE
        start_op(16'hB00D, 3'b010, 5'd1); wait_done(lat, sb);
        res_chk("b2b_a", lat, 1, 16'h5806, 1'b1, 1'b0, 1'b0);
        start_op(16'h8001, 3'b100, 5'd1);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_done", 32'(done), 32'd0);
        wait_done(lat, sb);
        res_chk("b2b_b", lat, 1, 16'hC000, 1'b1, 1'b0, 1'b0);

        // Reset mid-SHIFT discards the operation
        start_op(16'hB00D, 3'b001, 5'd9);
        repeat (3) begin @(posedge clk); #1; end
        chk("mid_busy_pre", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_sout", 32'(sout), 32'd0);
        @(posedge clk); #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_sout", 32'(sout), 32'd0);
        chk("mrst_zero", 32'(zero), 32'd1);
        chk("mrst_cout", 32'(cout), 32'd0);
        @(negedge clk); reset = 1'b0;
        saw_done = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        chk("mrst_no_done", 32'(saw_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
